// File: rtl/executor_rega.sv
// executor_rega: irrigation actuator sequencer.
// Opens valve, runs pump, purges, and latches failures.
module executor_rega #(
  parameter int T_ABERTURA = 4,
  parameter int T_MIN      = 8,
  parameter int T_PURGA    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] rega,
  input  logic       erro,
  output logic       valv_asp,
  output logic       valv_got,
  output logic       bomba,
  output logic       falha,
  output logic       fim,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    ABRINDO  = 3'd1,
    REGANDO  = 3'd2,
    FECHANDO = 3'd3,
    FALHA    = 3'd4
  } st_t;

  localparam logic [7:0] TA1 = 8'(T_ABERTURA - 1);
  localparam logic [7:0] TM1 = 8'(T_MIN - 1);
  localparam logic [7:0] TP1 = 8'(T_PURGA - 1);

  st_t        st_q;
  st_t        st_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       modo_q;
  logic       modo_d;
  logic       pend_q;
  logic       pend_d;
  logic       fim_q;
  logic       fim_d;

  logic       cmd_asp;
  logic       cmd_got;
  logic       cmd_bad;
  logic       cmd_none;
  logic [1:0] modo_code;
  logic       dropped;
  logic       act;

  // command decode against the latched mode
  always_comb begin
    cmd_asp   = (rega == 2'b10);
    cmd_got   = (rega == 2'b01);
    cmd_bad   = (rega == 2'b11);
    cmd_none  = (rega == 2'b00);
    modo_code = modo_q ? 2'b10 : 2'b01;
    dropped   = (rega != modo_code);
  end

  // state register and sequencing counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= OCIOSO;
      cnt_q  <= 8'd0;
      modo_q <= 1'b0;
      pend_q <= 1'b0;
      fim_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      modo_q <= modo_d;
      pend_q <= pend_d;
      fim_q  <= fim_d;
    end
  end

  // next-state logic; any error in a run forces a purge then FALHA
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    modo_d = modo_q;
    pend_d = pend_q;
    fim_d  = 1'b0;
    case (st_q)
      OCIOSO: begin
        if (erro || cmd_bad) begin
          st_d = FALHA;
        end else if (cmd_asp || cmd_got) begin
          modo_d = cmd_asp;
          cnt_d  = 8'd0;
          st_d   = ABRINDO;
        end
      end
      ABRINDO: begin
        if (erro) begin
          pend_d = 1'b1;
          cnt_d  = 8'd0;
          st_d   = FECHANDO;
        end else if (cnt_q == TA1) begin
          cnt_d = 8'd0;
          st_d  = REGANDO;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REGANDO: begin
        if (erro) begin
          pend_d = 1'b1;
          cnt_d  = 8'd0;
          st_d   = FECHANDO;
        end else if (dropped && cnt_q >= TM1) begin
          cnt_d = 8'd0;
          st_d  = FECHANDO;
        end else if (cnt_q != 8'hff) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FECHANDO: begin
        if (cnt_q == TP1) begin
          cnt_d = 8'd0;
          if (pend_q) begin
            st_d = FALHA;
          end else begin
            st_d  = OCIOSO;
            fim_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      FALHA: begin
        pend_d = 1'b0;
        if (!erro && cmd_none) begin
          st_d = OCIOSO;
        end
      end
      default: begin
        st_d   = OCIOSO;
        cnt_d  = 8'd0;
        pend_d = 1'b0;
      end
    endcase
  end

  // actuator decode from registers only
  always_comb begin
    act      = (st_q == ABRINDO) ||
               (st_q == REGANDO) ||
               (st_q == FECHANDO);
    valv_asp = act && modo_q;
    valv_got = act && !modo_q;
    bomba    = (st_q == REGANDO);
    falha    = (st_q == FALHA);
    estado   = st_q;
    fim      = fim_q;
  end

endmodule

// File: tb/tb_executor_rega.sv
// tb_executor_rega: directed per-cycle vectors
// plus async-reset sequence for executor_rega.
module tb_executor_rega;

  logic       clk;
  logic       reset_n;
  logic [1:0] rega;
  logic       erro;
  logic       valv_asp;
  logic       valv_got;
  logic       bomba;
  logic       falha;
  logic       fim;
  logic [2:0] estado;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [1:0] r;
    logic       e;
    logic [2:0] st;
    logic       asp;
    logic       got;
    logic       bom;
    logic       fal;
    logic       fm;
  } vec_t;

  vec_t vq[$];

  executor_rega #(
    .T_ABERTURA(4),
    .T_MIN(8),
    .T_PURGA(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rega(rega),
    .erro(erro),
    .valv_asp(valv_asp),
    .valv_got(valv_got),
    .bomba(bomba),
    .falha(falha),
    .fim(fim),
    .estado(estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(
    input int n,
    input logic [1:0] r, input logic e,
    input logic [2:0] st,
    input logic asp, input logic got,
    input logic bom, input logic fal,
    input logic fm
  );
    vec_t v;
    v.r = r; v.e = e; v.st = st;
    v.asp = asp; v.got = got;
    v.bom = bom; v.fal = fal; v.fm = fm;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic check(
    input string nm, input int idx,
    input logic [2:0] st,
    input logic asp, input logic got,
    input logic bom, input logic fal,
    input logic fm
  );
    n_chk++;
    if (estado !== st || valv_asp !== asp ||
        valv_got !== got || bomba !== bom ||
        falha !== fal || fim !== fm) begin
      n_fail++;
      $display("FAIL %s #%0d: got est=%0d asp=%b got=%b bomba=%b falha=%b fim=%b, want est=%0d asp=%b got=%b bomba=%b falha=%b fim=%b",
               nm, idx, estado, valv_asp, valv_got,
               bomba, falha, fim, st, asp, got,
               bom, fal, fm);
    end
  endtask

  task automatic step(
    input logic [1:0] r, input logic e
  );
    rega = r;
    erro = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // idle after reset
    add(2, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // asp held 20 cycles then dropped
    add(4, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    add(16, 2'b10, 0, 2, 1, 0, 1, 0, 0);
    add(3, 2'b00, 0, 3, 1, 0, 0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // got for a single cycle
    add(1, 2'b01, 0, 1, 0, 1, 0, 0, 0);
    add(3, 2'b00, 0, 1, 0, 1, 0, 0, 0);
    add(8, 2'b00, 0, 2, 0, 1, 1, 0, 0);
    add(3, 2'b00, 0, 3, 0, 1, 0, 0, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 1);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // error on 2nd REGANDO cycle
    add(4, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    add(2, 2'b10, 0, 2, 1, 0, 1, 0, 0);
    add(1, 2'b10, 1, 3, 1, 0, 0, 0, 0);
    add(2, 2'b10, 0, 3, 1, 0, 0, 0, 0);
    add(3, 2'b10, 0, 4, 0, 0, 0, 1, 0);
    add(2, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // invalid command and error-wins
    add(1, 2'b11, 0, 4, 0, 0, 0, 1, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2'b10, 1, 4, 0, 0, 0, 1, 0);
    add(1, 2'b00, 1, 4, 0, 0, 0, 1, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // error during ABRINDO
    add(1, 2'b01, 0, 1, 0, 1, 0, 0, 0);
    add(1, 2'b01, 1, 3, 0, 1, 0, 0, 0);
    add(2, 2'b01, 1, 3, 0, 1, 0, 0, 0);
    add(1, 2'b00, 0, 4, 0, 0, 0, 1, 0);
    add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // mode change mid-run: close, then re-accept
    add(4, 2'b10, 0, 1, 1, 0, 0, 0, 0);
    add(8, 2'b01, 0, 2, 1, 0, 1, 0, 0);
    add(3, 2'b01, 0, 3, 1, 0, 0, 0, 0);
    add(1, 2'b01, 0, 0, 0, 0, 0, 0, 1);
    add(1, 2'b01, 0, 1, 0, 1, 0, 0, 0);

    rega    = 2'b00;
    erro    = 1'b0;
    reset_n = 1'b0;
    #12;
    check("reset", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].r, vq[i].e);
      check("vec", i, vq[i].st, vq[i].asp,
            vq[i].got, vq[i].bom, vq[i].fal,
            vq[i].fm);
    end

    // async reset mid-REGANDO
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step(2'b00, 0);
    check("pre", 0, 0, 0, 0, 0, 0, 0);
    step(2'b10, 0);
    for (int i = 0; i < 5; i++) step(2'b10, 0);
    check("run", 0, 2, 1, 0, 1, 0, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("hold", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    step(2'b01, 0);
    check("rst_req", 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(2'b00, 0);
    check("rst_abr", 0, 1, 0, 1, 0, 0, 0);
    step(2'b00, 0);
    check("rst_reg", 0, 2, 0, 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
